cordic_vec: RTL and testbench
=============================

CORDIC_VEC -- requirements
Module: cordic_vec

Interface
REQ-001 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  request to begin a conversion; sampled only in IDLE.
REQ-005 x_i  input  16  signed Q8.7 vector X component; captured on accepted start.
REQ-006 y_i  input  16  signed Q8.7 vector Y component; captured on accepted start.
REQ-007 mag_o  output  16  signed Q8.7 vector magnitude; registered; holds its value until the next completion.
REQ-008 angle_o  output  16  signed Q3.13 atan2(y,x) in radians (pi = 0x6488); registered; holds its value until the next completion.
REQ-009 ready  output  1  high in IDLE only.
REQ-010 valid_o  output  1  one-cycle pulse in the cycle mag_o/angle_o update.

Function
REQ-011 States SHALL be IDLE, PREROT, CALC, SCALE; the encoding is 2 bits.
REQ-012 IDLE with start=1 -> capture x_i/y_i sign-extended to 18 bits, clear the angle accumulator, ready=0, go to PREROT; start in any other state is ignored.
REQ-013 PREROT, x>=0 -> x, y and acc are unchanged.
REQ-014 PREROT, x<0, y>=0 -> (x,y) becomes (y,-x) and acc = +0x3244.
REQ-015 PREROT, x<0, y<0 -> (x,y) becomes (-y,x) and acc = -0x3244.
REQ-016 CALC SHALL run 8 iterations, i = cnt 0..7, one per cycle.
REQ-017 CALC iteration, y>=0: x += y>>>i, y -= x>>>i, acc += atan_tab[i].
REQ-018 CALC iteration, y<0: the signs in REQ-017 are inverted.
REQ-019 All CALC updates SHALL be simultaneous, using the pre-iteration values.
REQ-020 atan_tab (Q3.13) SHALL be 0x1922, 0x0ED6, 0x07D7, 0x03FB, 0x01FF, 0x0100, 0x0080, 0x0040.
REQ-021 SCALE: mag = (x * 0x4E) >>> 7, with K = 0.6073 in Q8.7.
REQ-022 SCALE: a mag above 0x7FFF SHALL saturate to 0x7FFF; angle_o = acc.
REQ-023 SCALE completion: valid_o=1, ready=1, go to IDLE.
REQ-024 Latency from the start-accept edge to valid_o SHALL be 10 cycles: 1 PREROT + 8 CALC + 1 SCALE.
REQ-025 x_i=y_i=0 SHALL produce mag_o=0 and angle_o=0, with no accumulated table angle.
REQ-026 x<0, y=0 SHALL produce angle_o=+0x6488 (+pi), never -pi.
REQ-027 Internal x/y SHALL be 18-bit signed so that CORDIC gain (1.647) times sqrt2 on full-scale input cannot overflow.
REQ-028 start asserted in the same cycle as valid_o SHALL NOT be accepted; it is accepted on the following IDLE cycle.

Reset
REQ-029 Reset asserted SHALL immediately force state=IDLE, cnt=0, internal x/y/acc=0, mag_o=0, angle_o=0, ready=1, valid_o=0.
REQ-030 Reset asserted mid-conversion SHALL abort the conversion with no valid_o pulse.
REQ-031 After reset deasserts, the first start SHALL behave per REQ-012.

Configuration
REQ-032 Macro CORDIC_VEC_SCALE_EN defined: the SCALE state applies K per REQ-021 and the latency is 10 cycles.
REQ-033 CORDIC_VEC_SCALE_EN undefined: the SCALE state is removed, CALC completion writes mag_o = x saturated to 16 bits (raw gain ~1.647), and the latency is 9 cycles.

Structure
REQ-034 Package cordic_pkg SHALL hold: the state enum, atan_tab, the K constant, the Q formats, PI and PI_2 constants, and the ITER=8 constant.
REQ-035 One sub-module, cordic_vec_stage (combinational single iteration: x, y, acc, shift, direction), SHALL be instantiated once and reused each cycle.

Verification
REQ-036 Bench scenario: x=0x0080, y=0 -> after 10 cycles valid_o pulses; mag_o=0x0080 +/-2 LSB; angle_o=0x0000 +/-80 LSB.
REQ-037 Bench scenario: x=0x0080, y=0x0080 -> mag_o=0x00B5 +/-3 LSB; angle_o=0x1922 +/-80 LSB.
REQ-038 Bench scenario: x=0xFF80, y=0 -> angle_o=0x6488 +/-80 LSB, positive; x=0, y=0xFF80 -> angle_o=-0x3244 +/-80 LSB.
REQ-039 Bench scenario: x=y=0 -> mag_o=0, angle_o=0 exactly; x=y=0x7FFF -> mag_o=0x7FFF (saturated).
REQ-040 Bench scenario: start pulsed again in cycles 3 and 10 of a conversion -> both ignored; exactly one valid_o pulse; outputs match the first operands.
REQ-041 Bench scenario: reset asserted in cycle 5 -> outputs zero and ready=1 immediately; no valid_o pulse; a new conversion completes correctly.

Source files
------------

// File: rtl/cordic_pkg.sv
// Shared types, fixed-point formats and constants for the cordic_vec vectoring CORDIC.
// Formats: ports Q8.7 (magnitude) and Q3.13 (angle); internal x/y are 18-bit signed.
package cordic_pkg;

  localparam int ITER     = 8;
  localparam int CNT_W    = 3;
  localparam int IO_W     = 16;
  localparam int XY_W     = 18;
  localparam int ACC_W    = 16;
  localparam int FRAC_Q87 = 7;
  localparam int FRAC_Q313 = 13;
  localparam int PROD_W   = XY_W + 9;

  localparam logic signed [8:0]       K_Q87 = 9'sh04E;
  localparam logic signed [ACC_W-1:0] PI    = 16'sh6488;
  localparam logic signed [ACC_W-1:0] PI_2  = 16'sh3244;

  localparam logic signed [PROD_W-1:0] SAT_HI = PROD_W'(32767);
  localparam logic signed [PROD_W-1:0] SAT_LO = PROD_W'(-32768);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_PREROT = 2'd1,
    ST_CALC   = 2'd2,
    ST_SCALE  = 2'd3
  } state_t;

  function automatic logic signed [ACC_W-1:0] atan_tab(input logic [CNT_W-1:0] i);
    case (i)
      3'd0:    return 16'sh1922;
      3'd1:    return 16'sh0ED6;
      3'd2:    return 16'sh07D7;
      3'd3:    return 16'sh03FB;
      3'd4:    return 16'sh01FF;
      3'd5:    return 16'sh0100;
      3'd6:    return 16'sh0080;
      default: return 16'sh0040;
    endcase
  endfunction

  function automatic logic [IO_W-1:0] sat_q87(input logic signed [PROD_W-1:0] v);
    if (v > SAT_HI) return 16'h7FFF;
    if (v < SAT_LO) return 16'h8000;
    return v[IO_W-1:0];
  endfunction

endpackage

// File: rtl/cordic_vec_stage.sv
// One combinational vectoring iteration; dir_neg selects the rotation used when y is negative.
module cordic_vec_stage
  import cordic_pkg::*;
(
  input  logic signed [XY_W-1:0]  x,
  input  logic signed [XY_W-1:0]  y,
  input  logic signed [ACC_W-1:0] acc,
  input  logic [CNT_W-1:0]        shift,
  input  logic                    dir_neg,
  output logic signed [XY_W-1:0]  x_next,
  output logic signed [XY_W-1:0]  y_next,
  output logic signed [ACC_W-1:0] acc_next
);

  logic signed [XY_W-1:0]  x_sh;
  logic signed [XY_W-1:0]  y_sh;
  logic signed [ACC_W-1:0] ang;

  always_comb begin
    x_sh = x >>> shift;
    y_sh = y >>> shift;
    ang  = atan_tab(shift);
    if (dir_neg) begin
      x_next   = x - y_sh;
      y_next   = y + x_sh;
      acc_next = acc - ang;
    end else begin
      x_next   = x + y_sh;
      y_next   = y - x_sh;
      acc_next = acc + ang;
    end
  end

endmodule

// File: rtl/cordic_vec.sv
// Sequential vectoring CORDIC: magnitude and atan2 of (x_i, y_i), one iteration per cycle.
// Define CORDIC_VEC_SCALE_EN to add the SCALE state that applies the gain correction K.
//
// state  | meaning
// IDLE   | waiting for start, ready high
// PREROT | fold the left half-plane onto the right half-plane by +/- pi/2
// CALC   | ITER vectoring iterations, cnt = shift amount
// SCALE  | multiply x by K and publish results
module cordic_vec
  import cordic_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [IO_W-1:0] x_i,
  input  logic [IO_W-1:0] y_i,
  output logic [IO_W-1:0] mag_o,
  output logic [IO_W-1:0] angle_o,
  output logic            ready,
  output logic            valid_o
);

  state_t                  state;
  logic [CNT_W-1:0]        cnt;
  logic signed [XY_W-1:0]  x_q;
  logic signed [XY_W-1:0]  y_q;
  logic signed [ACC_W-1:0] acc_q;
  logic                    zero_in;
  logic signed [XY_W-1:0]  x_nx;
  logic signed [XY_W-1:0]  y_nx;
  logic signed [ACC_W-1:0] acc_nx;
  logic signed [ACC_W-1:0] acc_step;

  cordic_vec_stage u_stage (
    .x        (x_q),
    .y        (y_q),
    .acc      (acc_q),
    .shift    (cnt),
    .dir_neg  (y_q[XY_W-1]),
    .x_next   (x_nx),
    .y_next   (y_nx),
    .acc_next (acc_nx)
  );

  // A zero vector would otherwise collect the whole table as a bogus angle.
  assign acc_step = zero_in ? acc_q : acc_nx;

`ifdef CORDIC_VEC_SCALE_EN
  logic signed [PROD_W-1:0] prod;
  assign prod = PROD_W'(x_q) * PROD_W'(K_Q87);
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      x_q     <= '0;
      y_q     <= '0;
      acc_q   <= '0;
      zero_in <= 1'b0;
      mag_o   <= '0;
      angle_o <= '0;
      ready   <= 1'b1;
      valid_o <= 1'b0;
    end else begin
      valid_o <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start && !valid_o) begin
            x_q     <= XY_W'($signed(x_i));
            y_q     <= XY_W'($signed(y_i));
            acc_q   <= '0;
            cnt     <= '0;
            zero_in <= (x_i == '0) && (y_i == '0);
            ready   <= 1'b0;
            state   <= ST_PREROT;
          end
        end
        ST_PREROT: begin
          if (x_q[XY_W-1]) begin
            if (!y_q[XY_W-1]) begin
              x_q   <= y_q;
              y_q   <= -x_q;
              acc_q <= PI_2;
            end else begin
              x_q   <= -y_q;
              y_q   <= x_q;
              acc_q <= -PI_2;
            end
          end
          state <= ST_CALC;
        end
        ST_CALC: begin
          x_q   <= x_nx;
          y_q   <= y_nx;
          acc_q <= acc_step;
          cnt   <= cnt + 1'b1;
          if (cnt == CNT_W'(ITER - 1)) begin
`ifdef CORDIC_VEC_SCALE_EN
            state <= ST_SCALE;
`else
            mag_o   <= sat_q87(PROD_W'(x_nx));
            angle_o <= acc_step;
            valid_o <= 1'b1;
            ready   <= 1'b1;
            state   <= ST_IDLE;
`endif
          end
        end
`ifdef CORDIC_VEC_SCALE_EN
        ST_SCALE: begin
          mag_o   <= sat_q87(prod >>> FRAC_Q87);
          angle_o <= acc_q;
          valid_o <= 1'b1;
          ready   <= 1'b1;
          state   <= ST_IDLE;
        end
`endif
        default: begin
          state <= ST_IDLE;
          ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cordic_vec.sv
// Directed bench for cordic_vec; expectations follow CORDIC_VEC_SCALE_EN (scaled or raw gain).
module tb_cordic_vec;

`ifdef CORDIC_VEC_SCALE_EN
  localparam int LAT     = 10;
  localparam int MAG_A   = 128;
  localparam int MAG_B   = 181;
  localparam int TOL_A   = 2;
`else
  localparam int LAT     = 9;
  localparam int MAG_A   = 211;
  localparam int MAG_B   = 298;
  localparam int TOL_A   = 3;
`endif
  localparam int TOL_B   = 3;
  localparam int TOL_ANG = 80;

  logic        clk;
  logic        reset;
  logic        start;
  logic [15:0] x_i;
  logic [15:0] y_i;
  logic [15:0] mag_o;
  logic [15:0] angle_o;
  logic        ready;
  logic        valid_o;

  int n_checks = 0;
  int n_fail   = 0;

  cordic_vec dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .x_i     (x_i),
    .y_i     (y_i),
    .mag_o   (mag_o),
    .angle_o (angle_o),
    .ready   (ready),
    .valid_o (valid_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int adiff(input logic [15:0] a, input int e);
    int d;
    d = int'($signed(a)) - e;
    return (d < 0) ? -d : d;
  endfunction

  task automatic convert(input logic [15:0] xv, input logic [15:0] yv,
                         output logic [15:0] m, output logic [15:0] a, output int lat);
    @(posedge clk); #1;
    x_i = xv; y_i = yv; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = -1; m = '0; a = '0;
    for (int n = 1; n <= LAT + 5; n++) begin
      @(posedge clk); #1;
      if (valid_o) begin
        lat = n; m = mag_o; a = angle_o;
        break;
      end
    end
  endtask

  task automatic test_reset();
    n_checks++;
    if ({mag_o, angle_o} !== 32'h0) begin
      n_fail++; $display("FAIL reset_outputs: got mag=%h ang=%h expected 0000 0000", mag_o, angle_o);
    end
    n_checks++;
    if ({ready, valid_o} !== 2'b10) begin
      n_fail++; $display("FAIL reset_flags: got ready=%b valid=%b expected ready=1 valid=0", ready, valid_o);
    end
  endtask

  task automatic test_axis();
    logic [15:0] m, a; int lat;
    convert(16'h0080, 16'h0000, m, a, lat);
    n_checks++;
    if (lat !== LAT) begin n_fail++; $display("FAIL axis_latency: got %0d expected %0d", lat, LAT); end
    n_checks++;
    if (adiff(m, MAG_A) > TOL_A) begin n_fail++; $display("FAIL axis_mag: got %0d expected %0d", $signed(m), MAG_A); end
    n_checks++;
    if (adiff(a, 0) > TOL_ANG) begin n_fail++; $display("FAIL axis_angle: got %0d expected 0", $signed(a)); end
  endtask

  task automatic test_diag();
    logic [15:0] m, a; int lat;
    convert(16'h0080, 16'h0080, m, a, lat);
    n_checks++;
    if (lat !== LAT) begin n_fail++; $display("FAIL diag_latency: got %0d expected %0d", lat, LAT); end
    n_checks++;
    if (adiff(m, MAG_B) > TOL_B) begin n_fail++; $display("FAIL diag_mag: got %0d expected %0d", $signed(m), MAG_B); end
    n_checks++;
    if (adiff(a, 32'sh1922) > TOL_ANG) begin n_fail++; $display("FAIL diag_angle: got %0d expected %0d", $signed(a), 32'sh1922); end
  endtask

  task automatic test_neg_x();
    logic [15:0] m, a; int lat;
    convert(16'hFF80, 16'h0000, m, a, lat);
    n_checks++;
    if (lat !== LAT) begin n_fail++; $display("FAIL negx_latency: got %0d expected %0d", lat, LAT); end
    n_checks++;
    if (adiff(a, 32'sh6488) > TOL_ANG) begin n_fail++; $display("FAIL negx_angle: got %0d expected %0d", $signed(a), 32'sh6488); end
    n_checks++;
    if (a[15] !== 1'b0) begin n_fail++; $display("FAIL negx_sign: got sign %b expected 0", a[15]); end
    n_checks++;
    if (adiff(m, MAG_A) > TOL_B) begin n_fail++; $display("FAIL negx_mag: got %0d expected %0d", $signed(m), MAG_A); end
  endtask

  task automatic test_neg_y();
    logic [15:0] m, a; int lat;
    convert(16'h0000, 16'hFF80, m, a, lat);
    n_checks++;
    if (adiff(a, -32'sh3244) > TOL_ANG) begin n_fail++; $display("FAIL negy_angle: got %0d expected %0d", $signed(a), -32'sh3244); end
    n_checks++;
    if (adiff(m, MAG_A) > TOL_B) begin n_fail++; $display("FAIL negy_mag: got %0d expected %0d", $signed(m), MAG_A); end
  endtask

  task automatic test_zero();
    logic [15:0] m, a; int lat;
    convert(16'h0000, 16'h0000, m, a, lat);
    n_checks++;
    if (lat !== LAT) begin n_fail++; $display("FAIL zero_latency: got %0d expected %0d", lat, LAT); end
    n_checks++;
    if ({m, a} !== 32'h0) begin n_fail++; $display("FAIL zero_result: got mag=%h ang=%h expected 0000 0000", m, a); end
  endtask

  task automatic test_sat();
    logic [15:0] m, a; int lat;
    convert(16'h7FFF, 16'h7FFF, m, a, lat);
    n_checks++;
    if (lat !== LAT) begin n_fail++; $display("FAIL sat_latency: got %0d expected %0d", lat, LAT); end
    n_checks++;
    if (m !== 16'h7FFF) begin n_fail++; $display("FAIL sat_mag: got %h expected 7fff", m); end
  endtask

  task automatic test_start_ignored();
    logic [15:0] m, a; int pulses, first_n;
    @(posedge clk); #1;
    x_i = 16'h0080; y_i = 16'h0000; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; x_i = 16'h0000; y_i = 16'hFF80;
    pulses = 0; first_n = -1; m = '0; a = '0;
    for (int n = 1; n <= LAT + 12; n++) begin
      @(posedge clk); #1;
      if (valid_o) begin
        pulses++;
        if (first_n < 0) begin first_n = n; m = mag_o; a = angle_o; end
      end
      if (n == 3) begin
        n_checks++;
        if (ready !== 1'b0) begin n_fail++; $display("FAIL busy_ready: got %b expected 0", ready); end
      end
      start = (n == 3) || (n == LAT);
    end
    start = 1'b0;
    n_checks++;
    if (pulses !== 1) begin n_fail++; $display("FAIL ignore_pulses: got %0d expected 1", pulses); end
    n_checks++;
    if (first_n !== LAT) begin n_fail++; $display("FAIL ignore_latency: got %0d expected %0d", first_n, LAT); end
    n_checks++;
    if (adiff(m, MAG_A) > TOL_A) begin n_fail++; $display("FAIL ignore_mag: got %0d expected %0d", $signed(m), MAG_A); end
    n_checks++;
    if (adiff(a, 0) > TOL_ANG) begin n_fail++; $display("FAIL ignore_angle: got %0d expected 0", $signed(a)); end
  endtask

  task automatic test_reset_mid();
    logic [15:0] m, a; int lat, pulses;
    @(posedge clk); #1;
    x_i = 16'h0080; y_i = 16'h0080; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    n_checks++;
    if ({mag_o, angle_o} !== 32'h0) begin n_fail++; $display("FAIL midreset_outputs: got mag=%h ang=%h expected 0000 0000", mag_o, angle_o); end
    n_checks++;
    if ({ready, valid_o} !== 2'b10) begin n_fail++; $display("FAIL midreset_flags: got ready=%b valid=%b expected ready=1 valid=0", ready, valid_o); end
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    pulses = 0;
    for (int n = 0; n < LAT + 4; n++) begin
      @(posedge clk); #1;
      if (valid_o) pulses++;
    end
    n_checks++;
    if (pulses !== 0) begin n_fail++; $display("FAIL midreset_pulses: got %0d expected 0", pulses); end
    convert(16'h0080, 16'h0000, m, a, lat);
    n_checks++;
    if (lat !== LAT) begin n_fail++; $display("FAIL after_reset_latency: got %0d expected %0d", lat, LAT); end
    n_checks++;
    if (adiff(m, MAG_A) > TOL_A) begin n_fail++; $display("FAIL after_reset_mag: got %0d expected %0d", $signed(m), MAG_A); end
    n_checks++;
    if (adiff(a, 0) > TOL_ANG) begin n_fail++; $display("FAIL after_reset_angle: got %0d expected 0", $signed(a)); end
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; x_i = '0; y_i = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    test_reset();
    test_axis();
    test_diag();
    test_neg_x();
    test_neg_y();
    test_zero();
    test_sat();
    test_start_ignored();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
